pipe_stage_reg: RTL and testbench

- Parametrised inter-stage pipeline register for the five-stage MIPS core.
- Replaces hand-written stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one block.
- Carries an opaque payload plus the exception triple (code, EPC, BadVAddr) and an explicit valid bit.
- Applies the core's stall-vector/flush rules and adds payload-zeroing control and a stall-length performance counter.

---
 rtl/pipe_stage_reg_if.sv | 48 ++++
 rtl/pipe_stage_reg.sv | 158 +++++++++++++++
 tb/tb_pipe_stage_reg.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_reg_if.sv
// Stage-to-stage bus for pipe_stage_reg: upstream entry (payload, exception
// triple, valid) going in, and the registered copy coming out.
// master = the core side that feeds the stage and consumes its output.
// slave  = the pipeline register itself.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 213,
    parameter int EXC_W  = 5
);
    // Upstream entry presented to the stage
    logic              in_valid_i;
    logic [DATA_W-1:0] in_data_i;
    logic [EXC_W-1:0]  exc_code_i;
    logic [31:0]       exc_epc_i;
    logic [31:0]       exc_badvaddr_i;

    // Registered entry leaving the stage
    logic              out_valid_o;
    logic [DATA_W-1:0] out_data_o;
    logic [EXC_W-1:0]  exc_code_o;
    logic [31:0]       exc_epc_o;
    logic [31:0]       exc_badvaddr_o;

    modport master (
        output in_valid_i,
        output in_data_i,
        output exc_code_i,
        output exc_epc_i,
        output exc_badvaddr_i,
        input  out_valid_o,
        input  out_data_o,
        input  exc_code_o,
        input  exc_epc_o,
        input  exc_badvaddr_o
    );

    modport slave (
        input  in_valid_i,
        input  in_data_i,
        input  exc_code_i,
        input  exc_epc_i,
        input  exc_badvaddr_i,
        output out_valid_o,
        output out_data_o,
        output exc_code_o,
        output exc_epc_o,
        output exc_badvaddr_o
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register for the five-stage MIPS core.
// Carries an opaque payload, the exception triple (code, EPC, BadVAddr) and
// a valid bit. Each edge resolves to one of FLUSH > BUBBLE > HOLD > ADVANCE
// from flush and the two stall-vector bits around this stage. Also reports a
// one-cycle bubble marker and a saturating count of consecutive stall cycles.
// Every output is a flop; nothing on the input side reaches an output
// combinationally.
module pipe_stage_reg #(
    parameter int DATA_W      = 213,
    parameter int STALL_W     = 6,
    parameter int STAGE       = 3,
    parameter int EXC_W       = 5,
    parameter int EXC_NONE    = 0,
    parameter int ZERO_BUBBLE = 1,
    parameter int CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst,          // asynchronous, active low
    input  logic [STALL_W-1:0] stall,        // 1 = STOP
    input  logic               flush,
    pipe_stage_reg_if.slave    bus,
    output logic               bubble_o,
    output logic [CNT_W-1:0]   stall_cnt_o
);

    // The upstream bit is STAGE and the downstream bit is STAGE+1, so both
    // have to fall inside the stall vector.
    if (STAGE < 0 || STAGE > STALL_W - 2) begin : g_bad_stage
        $error("pipe_stage_reg: STAGE=%0d out of range for STALL_W=%0d",
               STAGE, STALL_W);
    end

    localparam logic [EXC_W-1:0] EXC_NONE_C = EXC_W'(EXC_NONE);
    localparam bit               ZERO_C     = (ZERO_BUBBLE != 0);

    typedef enum logic [1:0] {
        ACT_ADVANCE,
        ACT_HOLD,
        ACT_BUBBLE,
        ACT_FLUSH
    } action_e;

    logic    stall_up;
    logic    stall_dn;
    action_e act;

    // Only two bits of the stall vector matter here; fold the rest into a
    // sink so the unused upper/lower bits are accounted for.
    logic unused_stall;
    assign unused_stall = ^stall;

    assign stall_up = stall[STAGE];
    assign stall_dn = stall[STAGE+1];

    // Registered copies of the entry.
    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic [EXC_W-1:0]  code_q;
    logic [31:0]       epc_q;
    logic [31:0]       badvaddr_q;
    logic              bubble_q;
    logic [CNT_W-1:0]  cnt_q;

    // Pick this edge's action by priority. stall_up=0 with stall_dn=1 cannot
    // happen in the core and simply falls through to ADVANCE.
    always_comb begin
        // NOTE: default assignment first, so every path writes act and no
        // latch is inferred.
        act = ACT_ADVANCE;
        if (flush) begin
            act = ACT_FLUSH;
        end else if (stall_up) begin
            act = stall_dn ? ACT_HOLD : ACT_BUBBLE;
        end
    end

    // Entry register: clear on flush/bubble/invalid load, keep on hold,
    // load the upstream entry (exception and all) on advance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: non-blocking assignments in clocked blocks, so every flop
            // samples pre-edge values regardless of statement order.
            valid_q    <= 1'b0;
            data_q     <= '0;
            code_q     <= EXC_NONE_C;
            epc_q      <= '0;
            badvaddr_q <= '0;
        end else begin
            unique case (act)
                ACT_FLUSH, ACT_BUBBLE: begin
                    valid_q <= 1'b0;
                    code_q  <= EXC_NONE_C;
                    if (ZERO_C) begin
                        data_q     <= '0;
                        epc_q      <= '0;
                        badvaddr_q <= '0;
                    end
                end
                ACT_HOLD: begin
                    // every field keeps its value
                end
                ACT_ADVANCE: begin
                    if (bus.in_valid_i) begin
                        valid_q    <= 1'b1;
                        data_q     <= bus.in_data_i;
                        code_q     <= bus.exc_code_i;
                        epc_q      <= bus.exc_epc_i;
                        badvaddr_q <= bus.exc_badvaddr_i;
                    end else begin
                        valid_q <= 1'b0;
                        code_q  <= EXC_NONE_C;
                        if (ZERO_C) begin
                            data_q     <= '0;
                            epc_q      <= '0;
                            badvaddr_q <= '0;
                        end
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    code_q  <= EXC_NONE_C;
                end
            endcase
        end
    end

    // Bubble marker: high for exactly the cycle after a bubble was inserted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bubble_q <= 1'b0;
        end else begin
            bubble_q <= (act == ACT_BUBBLE);
        end
    end

    // Stall-length counter: counts BUBBLE and HOLD cycles alike, saturates at
    // all-ones, clears on ADVANCE and FLUSH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (act == ACT_BUBBLE || act == ACT_HOLD) begin
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_q <= '0;
        end
    end

    assign bus.out_valid_o    = valid_q;
    assign bus.out_data_o     = data_q;
    assign bus.exc_code_o     = code_q;
    assign bus.exc_epc_o      = epc_q;
    assign bus.exc_badvaddr_o = badvaddr_q;
    assign bubble_o           = bubble_q;
    assign stall_cnt_o        = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg. Three instances share one stimulus:
//   dut_a: default parameters (CNT_W=8, ZERO_BUBBLE=1)
//   dut_b: CNT_W=2, to reach counter saturation
//   dut_c: ZERO_BUBBLE=0, where cleared entries keep payload/EPC/BadVAddr
module tb_pipe_stage_reg;

    localparam int DATA_W  = 213;
    localparam int STALL_W = 6;
    localparam int EXC_W   = 5;

    localparam logic [STALL_W-1:0] ST_NONE   = 6'b000000;
    localparam logic [STALL_W-1:0] ST_BUBBLE = 6'b001000;
    localparam logic [STALL_W-1:0] ST_HOLD   = 6'b011000;

    logic               clk;
    logic               rst;
    logic [STALL_W-1:0] stall;
    logic               flush;

    logic              bubble_a, bubble_b, bubble_c;
    logic [7:0]        cnt_a;
    logic [1:0]        cnt_b;
    logic [7:0]        cnt_c;

    int checks = 0;
    int passed = 0;

    pipe_stage_reg_if #(.DATA_W(DATA_W), .EXC_W(EXC_W)) bus_a ();
    pipe_stage_reg_if #(.DATA_W(DATA_W), .EXC_W(EXC_W)) bus_b ();
    pipe_stage_reg_if #(.DATA_W(DATA_W), .EXC_W(EXC_W)) bus_c ();

    pipe_stage_reg dut_a (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .bus(bus_a), .bubble_o(bubble_a), .stall_cnt_o(cnt_a)
    );

    pipe_stage_reg #(.CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .bus(bus_b), .bubble_o(bubble_b), .stall_cnt_o(cnt_b)
    );

    pipe_stage_reg #(.ZERO_BUBBLE(0)) dut_c (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .bus(bus_c), .bubble_o(bubble_c), .stall_cnt_o(cnt_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // The core never stops this stage while letting the next one stop.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            chk("legal_stall", {255'd0, (!stall[3] && stall[4])}, 256'd0);
        end
    end

    task automatic drive(input logic v, input logic [DATA_W-1:0] d,
                         input logic [EXC_W-1:0] c, input logic [31:0] epc,
                         input logic [31:0] bad);
        bus_a.in_valid_i = v; bus_a.in_data_i = d; bus_a.exc_code_i = c;
        bus_a.exc_epc_i = epc; bus_a.exc_badvaddr_i = bad;
        bus_b.in_valid_i = v; bus_b.in_data_i = d; bus_b.exc_code_i = c;
        bus_b.exc_epc_i = epc; bus_b.exc_badvaddr_i = bad;
        bus_c.in_valid_i = v; bus_c.in_data_i = d; bus_c.exc_code_i = c;
        bus_c.exc_epc_i = epc; bus_c.exc_badvaddr_i = bad;
    endtask

    // One rising edge, then settle just past it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst   = 1'b0;
        stall = ST_NONE;
        flush = 1'b0;
        drive(1'b0, '0, '0, '0, '0);

        // ---- reset state
        #3;
        chk("rst_valid",  256'(bus_a.out_valid_o), 256'd0);
        chk("rst_data",   256'(bus_a.out_data_o),  256'd0);
        chk("rst_code",   256'(bus_a.exc_code_o),  256'd0);
        chk("rst_epc",    256'(bus_a.exc_epc_o),   256'd0);
        chk("rst_bad",    256'(bus_a.exc_badvaddr_o), 256'd0);
        chk("rst_bubble", 256'(bubble_a), 256'd0);
        chk("rst_cnt",    256'(cnt_a), 256'd0);
        tick();
        rst = 1'b1;

        // ---- advance chain
        drive(1'b1, 213'h11, '0, '0, '0);
        tick();
        chk("adv1_data",   256'(bus_a.out_data_o), 256'h11);
        chk("adv1_valid",  256'(bus_a.out_valid_o), 256'd1);
        chk("adv1_bubble", 256'(bubble_a), 256'd0);
        drive(1'b1, 213'h22, '0, '0, '0);
        tick();
        chk("adv2_data",   256'(bus_a.out_data_o), 256'h22);
        chk("adv2_valid",  256'(bus_a.out_valid_o), 256'd1);
        drive(1'b1, 213'h33, '0, '0, '0);
        tick();
        chk("adv3_data",   256'(bus_a.out_data_o), 256'h33);
        chk("adv3_cnt",    256'(cnt_a), 256'd0);

        // ---- bubble for one cycle with 0x44 presented
        stall = ST_BUBBLE;
        drive(1'b1, 213'h44, '0, '0, '0);
        tick();
        chk("bub_valid",  256'(bus_a.out_valid_o), 256'd0);
        chk("bub_data",   256'(bus_a.out_data_o), 256'd0);
        chk("bub_code",   256'(bus_a.exc_code_o), 256'd0);
        chk("bub_bubble", 256'(bubble_a), 256'd1);
        chk("bub_cnt",    256'(cnt_a), 256'd1);
        chk("bub_zb0_data",  256'(bus_c.out_data_o), 256'h33);
        chk("bub_zb0_valid", 256'(bus_c.out_valid_o), 256'd0);
        stall = ST_NONE;
        tick();
        chk("bub_load_data",   256'(bus_a.out_data_o), 256'h44);
        chk("bub_load_valid",  256'(bus_a.out_valid_o), 256'd1);
        chk("bub_load_cnt",    256'(cnt_a), 256'd0);
        chk("bub_load_bubble", 256'(bubble_a), 256'd0);

        // ---- hold and saturation
        drive(1'b1, 213'h55, '0, '0, '0);
        tick();
        chk("hold_load", 256'(bus_a.out_data_o), 256'h55);
        stall = ST_HOLD;
        drive(1'b1, 213'h99, '0, '0, '0);
        tick();
        chk("hold1_cnt_b", 256'(cnt_b), 256'd1);
        tick();
        chk("hold2_cnt_b", 256'(cnt_b), 256'd2);
        tick();
        chk("hold3_cnt_b", 256'(cnt_b), 256'd3);
        tick();
        chk("hold4_cnt_b", 256'(cnt_b), 256'd3);
        tick();
        chk("hold5_cnt_b",  256'(cnt_b), 256'd3);
        chk("hold5_cnt_a",  256'(cnt_a), 256'd5);
        chk("hold5_data",   256'(bus_a.out_data_o), 256'h55);
        chk("hold5_valid",  256'(bus_a.out_valid_o), 256'd1);
        chk("hold5_bubble", 256'(bubble_a), 256'd0);
        chk("hold5_data_b", 256'(bus_b.out_data_o), 256'h55);

        // ---- flush beats stall
        stall = ST_NONE;
        drive(1'b1, 213'h66, '0, '0, '0);
        tick();
        chk("fl_cnt_clr", 256'(cnt_b), 256'd0);
        stall = ST_HOLD;
        tick();
        chk("fl_hold_cnt", 256'(cnt_a), 256'd1);
        flush = 1'b1;
        tick();
        chk("fl_valid",      256'(bus_a.out_valid_o), 256'd0);
        chk("fl_data",       256'(bus_a.out_data_o), 256'd0);
        chk("fl_cnt",        256'(cnt_a), 256'd0);
        chk("fl_bubble",     256'(bubble_a), 256'd0);
        chk("fl_zb0_data",   256'(bus_c.out_data_o), 256'h66);
        chk("fl_zb0_valid",  256'(bus_c.out_valid_o), 256'd0);
        flush = 1'b0;
        stall = ST_NONE;

        // ---- exception carry, then flush clears it
        drive(1'b1, 213'h77, 5'h04, 32'hBFC0_0100, 32'h0000_0003);
        tick();
        chk("exc_code",  256'(bus_a.exc_code_o), 256'h04);
        chk("exc_epc",   256'(bus_a.exc_epc_o), 256'hBFC0_0100);
        chk("exc_bad",   256'(bus_a.exc_badvaddr_o), 256'h3);
        chk("exc_valid", 256'(bus_a.out_valid_o), 256'd1);
        chk("exc_data",  256'(bus_a.out_data_o), 256'h77);
        flush = 1'b1;
        tick();
        chk("exfl_code",    256'(bus_a.exc_code_o), 256'd0);
        chk("exfl_epc",     256'(bus_a.exc_epc_o), 256'd0);
        chk("exfl_zb0_code", 256'(bus_c.exc_code_o), 256'd0);
        chk("exfl_zb0_epc", 256'(bus_c.exc_epc_o), 256'hBFC0_0100);
        flush = 1'b0;

        // ---- advance with an invalid entry
        drive(1'b0, 213'h88, 5'h04, 32'h1, 32'h2);
        tick();
        chk("inv_valid",     256'(bus_a.out_valid_o), 256'd0);
        chk("inv_code",      256'(bus_a.exc_code_o), 256'd0);
        chk("inv_data",      256'(bus_a.out_data_o), 256'd0);
        chk("inv_bad",       256'(bus_a.exc_badvaddr_o), 256'd0);
        chk("inv_zb0_code",  256'(bus_c.exc_code_o), 256'd0);
        chk("inv_zb0_data",  256'(bus_c.out_data_o), 256'h77);
        chk("inv_zb0_bad",   256'(bus_c.exc_badvaddr_o), 256'h3);

        // ---- reset mid-hold, asynchronously between edges
        drive(1'b1, 213'h1ABC, '0, 32'h10, 32'h20);
        tick();
        chk("rh_load", 256'(bus_a.out_data_o), 256'h1ABC);
        stall = ST_HOLD;
        tick();
        tick();
        tick();
        chk("rh_cnt", 256'(cnt_a), 256'd3);
        chk("rh_data", 256'(bus_a.out_data_o), 256'h1ABC);
        #3;
        rst = 1'b0;
        #1;
        chk("rh_valid", 256'(bus_a.out_valid_o), 256'd0);
        chk("rh_data0", 256'(bus_a.out_data_o), 256'd0);
        chk("rh_code",  256'(bus_a.exc_code_o), 256'd0);
        chk("rh_epc",   256'(bus_a.exc_epc_o), 256'd0);
        chk("rh_cnt0",  256'(cnt_a), 256'd0);
        chk("rh_cnt_b", 256'(cnt_b), 256'd0);
        chk("rh_zb0_data", 256'(bus_c.out_data_o), 256'd0);
        stall = ST_NONE;
        tick();
        rst = 1'b1;
        drive(1'b1, 213'hAB, '0, '0, '0);
        tick();
        chk("post_rst_data", 256'(bus_a.out_data_o), 256'hAB);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
